// File: rtl/pc_gen.sv
// pc_gen: fetch-PC generator with a valid/ready request interface.
// Applies branch/jump redirects and trap vectors. A redirect that arrives
// while a request is outstanding is buffered. Each issued PC carries an
// epoch tag, and an ebreak halt drains the outstanding request first.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   pc_valid/pc_ready/pc      fetch request handshake and address
//   pc_epoch                  epoch tag of pc
//   stall                     suppress new requests
//   redirect_valid/_pc        branch/jump redirect
//   trap_valid/trap_pc        trap/mret vector (priority over redirect)
//   halt_req / halted         drained stop until reset
//   misalign / misalign_addr  rejected misaligned redirect report
module pc_gen #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_VAL  = WIDTH'(32'h80000000),
    parameter int unsigned      ALIGN_BITS = 2,
    parameter int unsigned      EPOCH_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               pc_valid,
    input  logic               pc_ready,
    output logic [WIDTH-1:0]   pc,
    output logic [EPOCH_W-1:0] pc_epoch,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [WIDTH-1:0]   redirect_pc,
    input  logic               trap_valid,
    input  logic [WIDTH-1:0]   trap_pc,
    input  logic               halt_req,
    output logic               halted,
    output logic               misalign,
    output logic [WIDTH-1:0]   misalign_addr
);

    localparam logic [WIDTH-1:0] INC        = WIDTH'(1) << ALIGN_BITS;
    localparam logic [WIDTH-1:0] ALIGN_MASK = INC - WIDTH'(1);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     pc_q, pc_d;
    logic                 pc_valid_q, pc_valid_d;
    logic [EPOCH_W-1:0]   pc_epoch_q, pc_epoch_d;
    logic [EPOCH_W-1:0]   epoch_cnt_q, epoch_cnt_d;
    logic                 pend_valid_q, pend_valid_d;
    logic                 pend_trap_q, pend_trap_d;
    logic [WIDTH-1:0]     pend_tgt_q, pend_tgt_d;
    logic                 halted_q, halted_d;
    logic                 misalign_q, misalign_d;
    logic [WIDTH-1:0]     misalign_addr_q, misalign_addr_d;

    // Event decode: trap beats redirect; misaligned redirects are rejected.
    logic             redir_aligned;
    logic             redir_ok;
    logic             redir_bad;
    logic             evt;
    logic [WIDTH-1:0] evt_tgt;
    logic             hs;
    logic             outstanding;

    assign redir_aligned = ((redirect_pc & ALIGN_MASK) == '0);
    assign redir_ok      = redirect_valid & ~trap_valid & redir_aligned;
    assign redir_bad     = redirect_valid & ~trap_valid & ~redir_aligned;
    assign evt           = trap_valid | redir_ok;
    assign evt_tgt       = trap_valid ? (trap_pc & ~ALIGN_MASK) : redirect_pc;
    assign hs            = pc_valid_q & pc_ready;
    assign outstanding   = pc_valid_q & ~pc_ready;

    // Next-state and datapath
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        pc_valid_d      = pc_valid_q;
        pc_epoch_d      = pc_epoch_q;
        epoch_cnt_d     = epoch_cnt_q;
        pend_valid_d    = pend_valid_q;
        pend_trap_d     = pend_trap_q;
        pend_tgt_d      = pend_tgt_q;
        halted_d        = halted_q;
        misalign_d      = 1'b0;
        misalign_addr_d = misalign_addr_q;

        // HALT freezes everything; only reset leaves it.
        if (state_q != ST_HALT) begin
            misalign_d = redir_bad;
            if (redir_bad) begin
                misalign_addr_d = redirect_pc;
            end
            if (evt) begin
                epoch_cnt_d = epoch_cnt_q + EPOCH_W'(1);
            end

            if (outstanding) begin
                // Request must stay stable: buffer the event. A pending
                // trap is only displaced by another trap.
                if (evt && (trap_valid || !(pend_valid_q && pend_trap_q))) begin
                    pend_valid_d = 1'b1;
                    pend_trap_d  = trap_valid;
                    pend_tgt_d   = evt_tgt;
                end
                if (state_q == ST_RUN && halt_req) begin
                    state_d = ST_DRAIN;
                end
            end else begin
                if (evt) begin
                    pc_d = evt_tgt;
                end else if (pend_valid_q) begin
                    pc_d = pend_tgt_q;
                end else if (hs) begin
                    pc_d = pc_q + INC;
                end
                pend_valid_d = 1'b0;
                pend_trap_d  = 1'b0;
                pc_epoch_d   = epoch_cnt_d;

                if (state_q == ST_DRAIN || (state_q == ST_RUN && halt_req)) begin
                    state_d    = ST_HALT;
                    pc_valid_d = 1'b0;
                    halted_d   = 1'b1;
                end else begin
                    state_d    = ST_RUN;
                    pc_valid_d = ~stall;
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_BOOT;
            pc_q            <= RESET_VAL;
            pc_valid_q      <= 1'b0;
            pc_epoch_q      <= '0;
            epoch_cnt_q     <= '0;
            pend_valid_q    <= 1'b0;
            pend_trap_q     <= 1'b0;
            pend_tgt_q      <= '0;
            halted_q        <= 1'b0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            pc_valid_q      <= pc_valid_d;
            pc_epoch_q      <= pc_epoch_d;
            epoch_cnt_q     <= epoch_cnt_d;
            pend_valid_q    <= pend_valid_d;
            pend_trap_q     <= pend_trap_d;
            pend_tgt_q      <= pend_tgt_d;
            halted_q        <= halted_d;
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    assign pc_valid      = pc_valid_q;
    assign pc            = pc_q;
    assign pc_epoch      = pc_epoch_q;
    assign halted        = halted_q;
    assign misalign      = misalign_q;
    assign misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        pc_valid;
    logic        pc_ready;
    logic [31:0] pc;
    logic [1:0]  pc_epoch;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic        halt_req;
    logic        halted;
    logic        misalign;
    logic [31:0] misalign_addr;

    // Second instance used only for the address-wrap case
    logic        w_valid;
    logic [31:0] w_pc;
    logic [1:0]  w_epoch;
    logic        w_halted;
    logic        w_mis;
    logic [31:0] w_maddr;

    int n_checks = 0;
    int n_fail   = 0;

    pc_gen dut (
        .clk(clk), .rst(rst),
        .pc_valid(pc_valid), .pc_ready(pc_ready), .pc(pc), .pc_epoch(pc_epoch),
        .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .trap_valid(trap_valid), .trap_pc(trap_pc),
        .halt_req(halt_req), .halted(halted),
        .misalign(misalign), .misalign_addr(misalign_addr)
    );

    pc_gen #(.RESET_VAL(32'hFFFFFFFC)) dut_w (
        .clk(clk), .rst(rst),
        .pc_valid(w_valid), .pc_ready(1'b1), .pc(w_pc), .pc_epoch(w_epoch),
        .stall(1'b0),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .trap_valid(1'b0), .trap_pc(32'h0),
        .halt_req(1'b0), .halted(w_halted),
        .misalign(w_mis), .misalign_addr(w_maddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic [1:0]  m_epoch;
    logic [1:0]  m_cnt;
    logic        m_halted;
    logic        m_mis;
    logic [31:0] m_maddr;
    logic        booting;
    logic        draining;
    logic        p_valid;
    logic        p_trap;
    logic [31:0] p_tgt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge of the specified behaviour, using the inputs held now.
    task automatic model_step();
        logic        has_evt;
        logic [31:0] tgt;
        logic        hs;
        logic        busy;
        if (rst) begin
            m_pc = 32'h80000000; m_valid = 0; m_epoch = 0; m_cnt = 0;
            m_halted = 0; m_mis = 0; m_maddr = 0;
            booting = 1; draining = 0; p_valid = 0; p_trap = 0; p_tgt = 0;
            return;
        end
        m_mis = 0;
        if (m_halted) return;
        hs      = m_valid && pc_ready;
        busy    = m_valid && !pc_ready;
        has_evt = 0;
        tgt     = 0;
        if (trap_valid) begin
            has_evt = 1;
            tgt     = {trap_pc[31:2], 2'b00};
        end else if (redirect_valid) begin
            if (redirect_pc % 4 == 0) begin
                has_evt = 1;
                tgt     = redirect_pc;
            end else begin
                m_mis   = 1;
                m_maddr = redirect_pc;
            end
        end
        if (has_evt) m_cnt = 2'((m_cnt + 1) % 4);
        if (busy) begin
            if (has_evt && (trap_valid || !(p_valid && p_trap))) begin
                p_valid = 1; p_trap = trap_valid; p_tgt = tgt;
            end
            if (!booting && !draining && halt_req) draining = 1;
        end else begin
            if (has_evt)      m_pc = tgt;
            else if (p_valid) m_pc = p_tgt;
            else if (hs)      m_pc = m_pc + 32'd4;
            p_valid = 0;
            m_epoch = m_cnt;
            if (draining || (!booting && halt_req)) begin
                m_halted = 1; m_valid = 0; draining = 0;
            end else begin
                m_valid = !stall;
            end
            booting = 0;
        end
    endtask

    task automatic compare();
        check("pc_valid",      32'(pc_valid), 32'(m_valid));
        check("pc",            pc,            m_pc);
        check("pc_epoch",      32'(pc_epoch), 32'(m_epoch));
        check("halted",        32'(halted),   32'(m_halted));
        check("misalign",      32'(misalign), 32'(m_mis));
        check("misalign_addr", misalign_addr, m_maddr);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic quiet();
        redirect_valid = 0; redirect_pc = 0;
        trap_valid = 0; trap_pc = 0; halt_req = 0;
    endtask

    int exp_ep[5] = '{1, 2, 3, 0, 1};

    initial begin
        logic [31:0] r;
        rst = 1; stall = 0; pc_ready = 1;
        quiet();
        m_pc = 0; m_valid = 0; m_epoch = 0; m_cnt = 0; m_halted = 0;
        m_mis = 0; m_maddr = 0; booting = 1; draining = 0;
        p_valid = 0; p_trap = 0; p_tgt = 0;

        // Reset and sequential fetch
        cyc(); cyc();
        check("rst_pc",     pc, 32'h80000000);
        check("rst_valid",  32'(pc_valid), 32'd0);
        check("rst_epoch",  32'(pc_epoch), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_maddr",  misalign_addr, 32'd0);
        rst = 0;
        cyc();
        check("boot_valid", 32'(pc_valid), 32'd1);
        check("seq_pc0", pc, 32'h80000000);
        check("wrap_pc0", w_pc, 32'hFFFFFFFC);
        cyc();
        check("seq_pc1", pc, 32'h80000004);
        check("wrap_pc1", w_pc, 32'h00000000);
        cyc();
        check("seq_pc2", pc, 32'h80000008);
        check("seq_epoch", 32'(pc_epoch), 32'd0);

        // Backpressure with redirect
        rst = 1; cyc(); rst = 0; cyc(); cyc();
        pc_ready = 0; cyc();
        redirect_valid = 1; redirect_pc = 32'h80000100; cyc();
        quiet(); cyc(); cyc();
        check("bp_hold_pc", pc, 32'h80000004);
        check("bp_hold_ep", 32'(pc_epoch), 32'd0);
        pc_ready = 1; cyc();
        check("bp_redir_pc", pc, 32'h80000100);
        check("bp_redir_ep", 32'(pc_epoch), 32'd1);

        // Trap versus redirect priority
        trap_valid = 1; trap_pc = 32'h80000203;
        redirect_valid = 1; redirect_pc = 32'h80000400; cyc();
        check("trap_pc", pc, 32'h80000200);
        check("trap_ep", 32'(pc_epoch), 32'd2);
        quiet(); pc_ready = 0; cyc();
        trap_valid = 1; trap_pc = 32'h80000300; cyc();
        quiet(); redirect_valid = 1; redirect_pc = 32'h80000500; cyc();
        quiet(); pc_ready = 1; cyc();
        check("trap_pend_pc", pc, 32'h80000300);
        check("trap_pend_ep", 32'(pc_epoch), 32'd0);

        // Misaligned redirect
        redirect_valid = 1; redirect_pc = 32'h80000102; cyc();
        check("mis_pulse", 32'(misalign), 32'd1);
        check("mis_addr", misalign_addr, 32'h80000102);
        check("mis_pc", pc, 32'h80000304);
        quiet(); cyc();
        check("mis_drop", 32'(misalign), 32'd0);
        check("mis_pc2", pc, 32'h80000308);

        // Halt drain
        pc_ready = 0; cyc();
        halt_req = 1; cyc();
        quiet(); cyc();
        check("drain_halted", 32'(halted), 32'd0);
        check("drain_valid", 32'(pc_valid), 32'd1);
        pc_ready = 1; cyc();
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_valid", 32'(pc_valid), 32'd0);
        check("halt_pc", pc, 32'h8000030C);
        for (int i = 0; i < 8; i++) begin
            redirect_valid = 1'($urandom); redirect_pc = $urandom;
            trap_valid = 1'($urandom); trap_pc = $urandom;
            pc_ready = 1'($urandom); stall = 1'($urandom);
            cyc();
        end
        check("halt_stay_valid", 32'(pc_valid), 32'd0);
        check("halt_stay_pc", pc, 32'h8000030C);
        quiet(); stall = 0; pc_ready = 1;

        // Epoch wrap, then reset in the middle of a drain
        rst = 1; cyc(); rst = 0; cyc();
        for (int i = 0; i < 5; i++) begin
            redirect_valid = 1; redirect_pc = 32'h80001000 + 32'(i * 16);
            cyc();
            check("epoch_wrap", 32'(pc_epoch), 32'(exp_ep[i]));
        end
        quiet(); pc_ready = 0; cyc();
        halt_req = 1; cyc();
        quiet(); rst = 1; pc_ready = 1; cyc();
        check("mrst_pc", pc, 32'h80000000);
        check("mrst_valid", 32'(pc_valid), 32'd0);
        check("mrst_epoch", 32'(pc_epoch), 32'd0);
        check("mrst_halted", 32'(halted), 32'd0);
        rst = 0;

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst            = ($urandom_range(0, 299) == 0);
            pc_ready       = ($urandom_range(0, 9) < 7);
            stall          = ($urandom_range(0, 9) < 2);
            redirect_valid = ($urandom_range(0, 99) < 15);
            r              = $urandom;
            redirect_pc    = ($urandom_range(0, 3) == 0) ? r : (r & ~32'h3);
            trap_valid     = ($urandom_range(0, 99) < 5);
            trap_pc        = $urandom;
            halt_req       = ($urandom_range(0, 199) == 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
